rc4_phase_sequencer: RTL

Top-level controller for the RC4 decryption core. It sequences the three client FSMs over one shared single-port working memory (S). The clients are the S-init filler, the per-index shuffle FSM and the decrypt FSM. The block owns the shuffle loop index i and the key index i mod KEY_LEN, and hands the S memory port to exactly one client at a time. It also watchdogs every client handshake.

---
 rtl/rc4_phase_sequencer_if.sv | 43 ++++
 rtl/rc4_phase_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rc4_phase_sequencer_if.sv
// Client handshakes and shared S-memory port of the RC4 phase sequencer.
// The sequencer is the master; the three clients and the memory sit on the slave side.
interface rc4_phase_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              init_start;
    logic              shuf_start;
    logic              dec_start;
    logic              init_fin;
    logic              shuf_fin;
    logic              dec_fin;
    logic [ADDR_W-1:0] init_addr;
    logic [ADDR_W-1:0] shuf_addr;
    logic [ADDR_W-1:0] dec_addr;
    logic [DATA_W-1:0] init_data;
    logic [DATA_W-1:0] shuf_data;
    logic [DATA_W-1:0] dec_data;
    logic              init_wren;
    logic              shuf_wren;
    logic              dec_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;

    modport master (
        output init_start, shuf_start, dec_start,
        input  init_fin, shuf_fin, dec_fin,
        input  init_addr, shuf_addr, dec_addr,
        input  init_data, shuf_data, dec_data,
        input  init_wren, shuf_wren, dec_wren,
        output mem_addr, mem_data, mem_wren
    );

    modport slave (
        input  init_start, shuf_start, dec_start,
        output init_fin, shuf_fin, dec_fin,
        output init_addr, shuf_addr, dec_addr,
        output init_data, shuf_data, dec_data,
        output init_wren, shuf_wren, dec_wren,
        input  mem_addr, mem_data, mem_wren
    );
endinterface

// File: rtl/rc4_phase_sequencer.sv
// Sequences S-init, N shuffle iterations and decrypt over one shared S port,
// owns the shuffle index i / key index and watchdogs every client handshake.
module rc4_phase_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int N       = 256,
    parameter int KEY_LEN = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_W-1:0]     iter_i,
    output logic [1:0]            key_idx,
    rc4_phase_sequencer_if.master bus
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_INIT_GO   = 4'd1;
    localparam logic [3:0] S_INIT_WAIT = 4'd2;
    localparam logic [3:0] S_SHUF_GO   = 4'd3;
    localparam logic [3:0] S_SHUF_WAIT = 4'd4;
    localparam logic [3:0] S_SHUF_NEXT = 4'd5;
    localparam logic [3:0] S_DEC_GO    = 4'd6;
    localparam logic [3:0] S_DEC_WAIT  = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;
    localparam logic [3:0] S_ERROR     = 4'd9;

    localparam logic [ADDR_W-1:0] LAST_I  = ADDR_W'(N - 1);
    localparam logic [1:0]        LAST_K  = 2'(KEY_LEN - 1);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

    logic [3:0]        state_q, state_d;
    logic [ADDR_W-1:0] iter_q, iter_d;
    logic [1:0]        key_q, key_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic              fin_sel;
    logic [3:0]        fin_nxt;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] data_mux;
    logic              wren_mux;

    always_comb begin
        fin_sel = 1'b0;
        fin_nxt = S_IDLE;
        case (state_q)
            S_INIT_WAIT: begin fin_sel = bus.init_fin; fin_nxt = S_SHUF_GO;   end
            S_SHUF_WAIT: begin fin_sel = bus.shuf_fin; fin_nxt = S_SHUF_NEXT; end
            S_DEC_WAIT:  begin fin_sel = bus.dec_fin;  fin_nxt = S_DONE;      end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        key_d   = key_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    state_d = S_INIT_GO;
                    iter_d  = '0;
                    key_d   = '0;
                    wd_d    = '0;
                end
            end
            S_INIT_GO: begin state_d = S_INIT_WAIT; wd_d = '0; end
            S_SHUF_GO: begin state_d = S_SHUF_WAIT; wd_d = '0; end
            S_DEC_GO:  begin state_d = S_DEC_WAIT;  wd_d = '0; end
            S_INIT_WAIT, S_SHUF_WAIT, S_DEC_WAIT: begin
                // The edge on which the count would reach TIMEOUT is the ERROR edge.
                if (fin_sel) begin
                    state_d = fin_nxt;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if (wd_q == WD_LAST) state_d = S_ERROR;
                end
            end
            S_SHUF_NEXT: begin
                if (iter_q == LAST_I) begin
                    state_d = S_DEC_GO;
                end else begin
                    iter_d  = iter_q + ADDR_W'(1);
                    key_d   = (key_q == LAST_K) ? 2'd0 : key_q + 2'd1;
                    state_d = S_SHUF_GO;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            key_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            key_q   <= key_d;
            wd_q    <= wd_d;
        end
    end

    // S port follows the owning client combinationally; no owner drives zeros.
    always_comb begin
        addr_mux = '0;
        data_mux = '0;
        wren_mux = 1'b0;
        case (state_q)
            S_INIT_GO, S_INIT_WAIT: begin
                addr_mux = bus.init_addr;
                data_mux = bus.init_data;
                wren_mux = bus.init_wren;
            end
            S_SHUF_GO, S_SHUF_WAIT, S_SHUF_NEXT: begin
                addr_mux = bus.shuf_addr;
                data_mux = bus.shuf_data;
                wren_mux = bus.shuf_wren;
            end
            S_DEC_GO, S_DEC_WAIT: begin
                addr_mux = bus.dec_addr;
                data_mux = bus.dec_data;
                wren_mux = bus.dec_wren;
            end
            default: ;
        endcase
    end

    assign bus.mem_addr   = addr_mux;
    assign bus.mem_data   = data_mux;
    assign bus.mem_wren   = wren_mux;
    assign bus.init_start = (state_q == S_INIT_GO);
    assign bus.shuf_start = (state_q == S_SHUF_GO);
    assign bus.dec_start  = (state_q == S_DEC_GO);

    assign busy    = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign done    = (state_q == S_DONE);
    assign err     = (state_q == S_ERROR);
    assign iter_i  = iter_q;
    assign key_idx = key_q;

endmodule
